fetch_stage: RTL

- Instruction-fetch stage of the 5-stage pipelined CPU.
- Owns the program counter and the PC+2 adder, and selects between sequential and branch/jump targets.
- Drives the combinational instruction-memory read and registers the result into the IF/ID buffer consumed by the decode stage.
- Honours hazard-unit stall, control-unit flush and halt. Provides saturating fetch/stall counters for the testbench display.

---
 rtl/cpu_pkg.sv | 17 +
 rtl/fetch_stage_if_id_buffer.sv | 38 +++
 rtl/fetch_stage.sv | 121 ++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath width, bubble encoding, fetch FSM
// states and the sequential PC increment.
package cpu_pkg;

    localparam int          CPU_WORD_W    = 16;
    localparam logic [15:0] CPU_NOP_INSTR = 16'h0000;

    // Instructions are one 16-bit word on a byte-addressed bus.
    localparam int          PC_INC        = 2;

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_stage_if_id_buffer.sv
// if_id_buffer: registered pipeline buffer carrying an instruction, its
// PC+2 and a valid bit. Priority: reset > flush > hold > load.
//   clock, reset  : clock, synchronous active-high reset
//   flush         : load a bubble (NOP_INSTR, pc_next 0, valid 0)
//   hold          : keep current contents
//   instruction_d : instruction to load
//   pc_next_d     : PC+2 of that instruction
//   instruction   : buffered instruction
//   pc_next       : buffered PC+2
//   valid         : buffer holds a real instruction
module if_id_buffer #(
    parameter int                WORD_W    = 16,
    parameter logic [WORD_W-1:0] NOP_INSTR = '0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              hold,
    input  logic [WORD_W-1:0] instruction_d,
    input  logic [WORD_W-1:0] pc_next_d,
    output logic [WORD_W-1:0] instruction,
    output logic [WORD_W-1:0] pc_next,
    output logic              valid
);

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            instruction <= NOP_INSTR;
            pc_next     <= '0;
            valid       <= 1'b0;
        end else if (!hold) begin
            instruction <= instruction_d;
            pc_next     <= pc_next_d;
            valid       <= 1'b1;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage. Owns the PC and its +2 adder,
// picks sequential vs. redirect targets, reads instruction memory
// combinationally and registers the result into the IF/ID buffer.
//   clock, reset        : clock, synchronous active-high reset
//   pc_stop             : freeze PC this cycle
//   if_id_hold          : IF/ID keeps its contents
//   if_id_flush         : load a bubble into IF/ID
//   halt                : stop fetching (sticky until reset)
//   pc_mux              : 1 = branch_target, 0 = PC+2
//   branch_target       : redirect address (bit 0 ignored)
//   imem_instruction    : instruction memory read data
//   imem_address        : registered PC
//   id_instruction      : IF/ID instruction
//   id_pc_next_address  : IF/ID PC+2
//   id_valid            : IF/ID holds a real instruction
//   halted              : stage is halted
//   fetch_count         : saturating count of valid IF/ID loads
//   stall_count         : saturating count of RUN stall/hold cycles
module fetch_stage
    import cpu_pkg::*;
#(
    parameter int                WORD_W    = CPU_WORD_W,
    parameter logic [WORD_W-1:0] RESET_PC  = '0,
    parameter logic [WORD_W-1:0] NOP_INSTR = WORD_W'(CPU_NOP_INSTR),
    parameter int                CNT_W     = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              pc_stop,
    input  logic              if_id_hold,
    input  logic              if_id_flush,
    input  logic              halt,
    input  logic              pc_mux,
    input  logic [WORD_W-1:0] branch_target,
    input  logic [WORD_W-1:0] imem_instruction,
    output logic [WORD_W-1:0] imem_address,
    output logic [WORD_W-1:0] id_instruction,
    output logic [WORD_W-1:0] id_pc_next_address,
    output logic              id_valid,
    output logic              halted,
    output logic [CNT_W-1:0]  fetch_count,
    output logic [CNT_W-1:0]  stall_count
);

    fetch_state_t      state;
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] pc_plus2;
    logic [WORD_W-1:0] pc_d;
    logic              buf_flush;
    logic              buf_hold;
    logic              buf_load;
    logic              stall_evt;

    assign imem_address = pc;

    always_comb begin
        // Adder wraps naturally at 2^WORD_W.
        pc_plus2 = pc + WORD_W'(PC_INC);

        // Halt beats redirect, redirect beats stop.
        pc_d = pc;
        if (state == RUN && !halt) begin
            if (pc_mux)
                pc_d = {branch_target[WORD_W-1:1], 1'b0};
            else if (!pc_stop)
                pc_d = pc_plus2;
        end

        // FILL keeps the reset bubble; HALTED keeps forcing the bubble.
        buf_flush = (state == HALTED) || (state == RUN && (halt || if_id_flush));
        buf_hold  = (state == FILL) || (state == RUN && if_id_hold);
        buf_load  = (state == RUN) && !halt && !if_id_flush && !if_id_hold;
        stall_evt = (state == RUN) && (pc_stop || if_id_hold);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= FILL;
            halted      <= 1'b0;
            pc          <= RESET_PC;
            fetch_count <= '0;
            stall_count <= '0;
        end else begin
            unique case (state)
                FILL:    state <= RUN;
                RUN: begin
                    if (halt) begin
                        state  <= HALTED;
                        halted <= 1'b1;
                    end
                end
                HALTED:  state <= HALTED;
                default: state <= FILL;
            endcase

            pc <= pc_d;

            // Counters stick at all-ones.
            if (buf_load && fetch_count != '1)
                fetch_count <= fetch_count + 1'b1;
            if (stall_evt && stall_count != '1)
                stall_count <= stall_count + 1'b1;
        end
    end

    if_id_buffer #(
        .WORD_W    (WORD_W),
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id (
        .clock         (clock),
        .reset         (reset),
        .flush         (buf_flush),
        .hold          (buf_hold),
        .instruction_d (imem_instruction),
        .pc_next_d     (pc_plus2),
        .instruction   (id_instruction),
        .pc_next       (id_pc_next_address),
        .valid         (id_valid)
    );

endmodule
